// File: rtl/amp_if_pkg.sv
// Shared types and helpers for the amplifier serial interface timing blocks.
// Divide exponents are 3 bits wide; legal values are 0..DIV_MAX.
package amp_if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  localparam int unsigned DIV_MAX = 5;
  localparam int unsigned DIV_W   = 3;
  localparam int unsigned HCNT_W  = 5;

  // Exponents above DIV_MAX saturate instead of wrapping to a fast clock.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] sel);
    return (sel > DIV_W'(DIV_MAX)) ? DIV_W'(DIV_MAX) : sel;
  endfunction

  // Terminal count of the half-period counter: 2^div - 1.
  function automatic logic [HCNT_W-1:0] half_tc(input logic [DIV_W-1:0] div);
    logic [HCNT_W:0] span;
    span = (HCNT_W+1)'(1) << div;
    return HCNT_W'(span - (HCNT_W+1)'(1));
  endfunction

endpackage

// File: rtl/sck_half_gen.sv
// Bit-clock half-period generator: counts clk_in cycles per sck half-period,
// toggles sck at terminal count and emits registered rise/fall strobes.
module sck_half_gen
  import amp_if_pkg::*;
(
  input  logic             clk_in,
  input  logic             resetb,
  input  logic [DIV_W-1:0] div_cur,
  input  logic             run,
  input  logic             clr,
  output logic             sck,
  output logic             sck_rise,
  output logic             sck_fall,
  output logic             fall_nxt
);

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              sck_q, sck_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              tc;

  // A sync clear restarts the half-period without toggling sck, so a ratio
  // switch can only ever lengthen the phase in progress.
  always_comb begin
    tc     = (hcnt_q == half_tc(div_cur));
    hcnt_d = hcnt_q + HCNT_W'(1);
    sck_d  = sck_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (!run) begin
      hcnt_d = '0;
      sck_d  = 1'b0;
    end else if (clr) begin
      hcnt_d = '0;
    end else if (tc) begin
      hcnt_d = '0;
      sck_d  = ~sck_q;
      rise_d = ~sck_q;
      fall_d = sck_q;
    end
  end

  assign fall_nxt = run && !clr && tc && sck_q;

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      hcnt_q <= '0;
      sck_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      sck_q  <= sck_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sck      = sck_q;
  assign sck_rise = rise_q;
  assign sck_fall = fall_q;

endmodule

// File: rtl/i2s_clk_sched.sv
// I2S bit-clock / word-select scheduler with frame-aligned ratio changes and stop.
//
//   state | meaning
//   IDLE  | clocks parked low, ratio requests applied immediately
//   RUN   | sck/ws running, ratio requests wait for a frame boundary
//   DRAIN | stop requested, running until the next frame boundary
module i2s_clk_sched
  import amp_if_pkg::*;
#(
  parameter int unsigned FRAME_BITS = 32,
  parameter int unsigned DIV_RST    = 5
) (
  input  logic             clk_in,
  input  logic             resetb,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_sel,
  input  logic             div_req,
  output logic             div_ack,
  output logic             sck,
  output logic             ws,
  output logic             sck_rise,
  output logic             sck_fall,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned BCNT_W = $clog2(2 * FRAME_BITS);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(2 * FRAME_BITS - 1);
  localparam logic [BCNT_W-1:0] BCNT_HALF = BCNT_W'(FRAME_BITS);

  sched_state_t      state_q, state_d;
  logic [DIV_W-1:0]  div_cur_q, div_cur_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              ws_q, ws_d;
  logic              frame_start_q, frame_start_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;

  logic pending;
  logic boundary;
  logic load;
  logic go_idle;
  logic run;
  logic hg_clr;
  logic fall_nxt;

  assign pending  = div_req && !ack_q;
  assign run      = (state_q != IDLE);
  assign boundary = run && frame_start_q;
  assign hg_clr   = boundary && (load || go_idle);

  always_comb begin
    state_d       = state_q;
    div_cur_d     = div_cur_q;
    bcnt_d        = bcnt_q;
    ws_d          = ws_q;
    frame_start_d = 1'b0;
    ack_d         = ack_q;
    load          = 1'b0;
    go_idle       = 1'b0;

    if (ack_q && !div_req) begin
      ack_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        bcnt_d = '0;
        ws_d   = 1'b0;
        load   = pending;
        if (enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        load = pending && boundary;
        if (!enable) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        load = pending && boundary;
        if (enable) begin
          state_d = RUN;
        end else if (boundary) begin
          state_d = IDLE;
          go_idle = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      div_cur_d = clamp_div(div_sel);
      ack_d     = 1'b1;
    end

    // Bit position and channel advance only on sck falling edges.
    if (run && fall_nxt) begin
      if (bcnt_q == BCNT_LAST) begin
        bcnt_d        = '0;
        frame_start_d = 1'b1;
      end else begin
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
      ws_d = (bcnt_d >= BCNT_HALF);
    end

    if (go_idle) begin
      ws_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      state_q       <= IDLE;
      div_cur_q     <= DIV_W'(DIV_RST);
      bcnt_q        <= '0;
      ws_q          <= 1'b0;
      frame_start_q <= 1'b0;
      ack_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cur_q     <= div_cur_d;
      bcnt_q        <= bcnt_d;
      ws_q          <= ws_d;
      frame_start_q <= frame_start_d;
      ack_q         <= ack_d;
      busy_q        <= busy_d;
    end
  end

  sck_half_gen u_half (
    .clk_in   (clk_in),
    .resetb   (resetb),
    .div_cur  (div_cur_q),
    .run      (run),
    .clr      (hg_clr),
    .sck      (sck),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .fall_nxt (fall_nxt)
  );

  assign ws          = ws_q;
  assign frame_start = frame_start_q;
  assign div_ack     = ack_q;
  assign busy        = busy_q;

endmodule
